gbt_counter_checker: RTL
========================

Name: gbt_counter_checker

Overview:
Receive-side checker for the GBT link test pattern. The transmitter puts a free-running 32-bit counter into motor_data_b64 as {cnt, cnt}; it increments once per tx frame clock and is cleared while SFP LOS is asserted. This block sits on the received-data side, in the rx frame clock domain, after gbt_xu5. It acquires lock on the pattern, flags and counts mismatching frames, and reports link-quality status for diag_x and the LEDs.

Parameters:
DATA_W, 64, received payload width; must be even; the halves are compared against each other.
LOCK_FRAMES, 16, consecutive good frames needed to reach LOCKED; range 1..255.
UNLOCK_ERRS, 4, consecutive bad frames in LOCKED that cause LOST; range 1..255.
CNT_W, 32, width of the error and frame counters.

Ports:
clk_ik  in  1  rx frame clock
rst_n_ir  in  1  synchronous reset, active low
los_i  in  1  SFP loss of signal; level input, already synchronised
clear_i  in  1  single-cycle pulse; zeroes the counters and does not change lock state
valid_i  in  1  data_i holds a new received frame this cycle
data_i  in  DATA_W  received payload
locked_o  out  1  FSM is in LOCKED
err_o  out  1  single-cycle pulse for each bad frame checked while LOCKED
err_cnt_o  out  CNT_W  bad frames seen in LOCKED; saturating
frame_cnt_o  out  CNT_W  frames checked in LOCKED; saturating
expected_o  out  DATA_W/2  next expected counter value

Behaviour:
- Reset (rst_n_ir = 0 at a clk_ik edge): state = ACQUIRE; all outputs and counters are 0; the internal good-run and bad-run counters are 0.
- Definitions: hi = data_i[DATA_W-1:DATA_W/2]; lo = data_i[DATA_W/2-1:0]. A frame is "consistent" when hi == lo. A frame is "good" when it is consistent and lo == expected_o. expected_o wraps modulo 2^(DATA_W/2), so 0xFFFFFFFF followed by 0x00000000 is good.
- Frames are evaluated only on cycles with valid_i = 1. With valid_i = 0 nothing changes except the clear_i action.
- Every valid frame loads expected_o <= lo + 1 when consistent, in every state.
- State ACQUIRE:
  - A consistent frame that is good, or is the first frame after entry, increments the good-run counter.
  - Any other frame sets the good-run counter to 0 (first frame after entry: 1 if consistent).
  - When the good-run count reaches LOCK_FRAMES, go to LOCKED on the same edge. The good-run counter is then 0.
- State LOCKED:
  - Each valid frame increments frame_cnt_o.
  - Good frame: bad-run counter = 0.
  - Bad frame: err_o = 1 for one cycle, err_cnt_o increments, bad-run counter increments. After a bad but consistent frame, expected_o resyncs to lo+1. After an inconsistent frame, expected_o increments by 1.
  - When the bad-run count reaches UNLOCK_ERRS, go to LOST.
- State LOST: lasts one cycle; clears the run counters; then goes to ACQUIRE.
- los_i = 1 has priority over the FSM: go to ACQUIRE, clear the run counters, expected_o = 0, err_o = 0. Counters hold. Frames are ignored while los_i = 1.
- clear_i: err_cnt_o and frame_cnt_o are 0 on the next edge. If clear_i coincides with an increment, clear wins.
- Counter saturation: both counters stop at all-ones.
- Latency: locked_o, err_o and the counters are registered outputs, one clock after the valid_i edge. No combinational path exists from input to output.

Optional Feature:
Macro GBT_COUNTER_CHECKER_SNAPSHOT_EN.
- Defined: adds output first_err_data_o [DATA_W-1:0] and first_err_exp_o [DATA_W/2-1:0].
  - They capture data_i and expected_o at the first bad frame in LOCKED after reset or clear_i, then hold.
  - They read 0 until that capture.
- Not defined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package (already imported by the top level): typedef enum logic [1:0] t_chk_state {ACQUIRE, LOCKED, LOST}, and constant GBT_PATTERN_W = 32.
- Natural sub-module: gbt_sat_counter. It is a CNT_W saturating counter with inc and clr inputs, with clr taking priority, and is instantiated twice.

Test Plan:
- Reset, then 16 valid frames {n,n} for n = 5..20 -> locked_o = 1 one cycle after the 16th frame; err_cnt_o = 0.
- Locked, then counter crosses 0xFFFFFFFF -> 0x00000000 -> no err_o; frame_cnt_o increments by 2.
- Locked, then one frame {7,8} (inconsistent) -> err_o pulses once; err_cnt_o = 1; next frame at the old expected+1 is good; stays locked.
- Locked, then 4 consecutive frames with a skipped value -> err_cnt_o = 4; LOST for one cycle; ACQUIRE; locked_o = 0; relocks after 16 good frames.
- los_i = 1 for 3 cycles mid-lock, then the stream restarts at 0 -> locked_o = 0 immediately; counters retain their values; relocks after 16 good frames.
- clear_i pulse on the same cycle as a bad frame -> err_cnt_o = 0 and frame_cnt_o = 0 after the edge; with the SNAPSHOT macro, the next bad frame is captured in first_err_data_o.

Source files
------------

// File: rtl/gbt_counter_checker_pkg.sv
// rtl/gbt_counter_checker_pkg.sv - shared types and constants for the GBT counter checker
package gbt_counter_checker_pkg;

  typedef enum logic [1:0] {
    ACQUIRE,
    LOCKED,
    LOST
  } t_chk_state;

  localparam int GBT_PATTERN_W = 32;

endpackage

// File: rtl/gbt_counter_checker_sat_counter.sv
// rtl/gbt_counter_checker_sat_counter.sv - saturating event counter with priority clear
module gbt_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_ik,
  input  logic         rst_n_ir,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_ik) begin
    if (!rst_n_ir) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/gbt_counter_checker.sv
// rtl/gbt_counter_checker.sv - lock/check FSM for the {cnt, cnt} GBT receive test pattern
// Optional first-error snapshot ports: GBT_COUNTER_CHECKER_SNAPSHOT_EN.
module gbt_counter_checker
  import gbt_counter_checker_pkg::*;
#(
  parameter int DATA_W      = 2 * GBT_PATTERN_W,
  parameter int LOCK_FRAMES = 16,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 32
) (
  input  logic                  clk_ik,
  input  logic                  rst_n_ir,
  input  logic                  los_i,
  input  logic                  clear_i,
  input  logic                  valid_i,
  input  logic [DATA_W-1:0]     data_i,
  output logic                  locked_o,
  output logic                  err_o,
  output logic [CNT_W-1:0]      err_cnt_o,
  output logic [CNT_W-1:0]      frame_cnt_o,
`ifdef GBT_COUNTER_CHECKER_SNAPSHOT_EN
  output logic [DATA_W-1:0]     first_err_data_o,
  output logic [DATA_W/2-1:0]   first_err_exp_o,
  output logic [DATA_W/2-1:0]   expected_o
`else
  output logic [DATA_W/2-1:0]   expected_o
`endif
);

  localparam int              HW      = DATA_W / 2;
  localparam logic [HW-1:0]   ONE     = HW'(1);
  localparam logic [7:0]      LOCK_C  = 8'(LOCK_FRAMES);
  localparam logic [7:0]      UNLCK_C = 8'(UNLOCK_ERRS);

  t_chk_state     state_q, state_d;
  logic [7:0]     good_run_q, good_run_d;
  logic [7:0]     bad_run_q, bad_run_d;
  logic           first_q, first_d;
  logic [HW-1:0]  expected_q, expected_d;
  logic           err_q, err_d;
  logic           frame_inc;
  logic           err_inc;

  logic [HW-1:0]  hi, lo;
  logic           consistent, good;

  assign hi         = data_i[DATA_W-1:HW];
  assign lo         = data_i[HW-1:0];
  assign consistent = (hi == lo);
  assign good       = consistent && (lo == expected_q);

  always_comb begin
    state_d    = state_q;
    good_run_d = good_run_q;
    bad_run_d  = bad_run_q;
    first_d    = first_q;
    expected_d = expected_q;
    err_d      = 1'b0;
    frame_inc  = 1'b0;
    err_inc    = 1'b0;

    if (los_i) begin
      state_d    = ACQUIRE;
      good_run_d = '0;
      bad_run_d  = '0;
      first_d    = 1'b1;
      expected_d = '0;
    end else begin
      if (valid_i && consistent) begin
        expected_d = lo + ONE;
      end
      unique case (state_q)
        ACQUIRE: begin
          if (valid_i) begin
            first_d = 1'b0;
            // The first frame after entry seeds the run even though expected is stale.
            if (consistent && (good || first_q)) begin
              if (good_run_q + 8'd1 == LOCK_C) begin
                state_d    = LOCKED;
                good_run_d = '0;
                bad_run_d  = '0;
              end else begin
                good_run_d = good_run_q + 8'd1;
              end
            end else begin
              good_run_d = '0;
            end
          end
        end
        LOCKED: begin
          if (valid_i) begin
            frame_inc = 1'b1;
            if (good) begin
              bad_run_d = '0;
            end else begin
              err_d   = 1'b1;
              err_inc = 1'b1;
              if (!consistent) begin
                expected_d = expected_q + ONE;
              end
              bad_run_d = bad_run_q + 8'd1;
              if (bad_run_q + 8'd1 == UNLCK_C) begin
                state_d = LOST;
              end
            end
          end
        end
        LOST: begin
          state_d    = ACQUIRE;
          good_run_d = '0;
          bad_run_d  = '0;
          first_d    = 1'b1;
        end
        default: begin
          state_d = ACQUIRE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_ik) begin
    if (!rst_n_ir) begin
      state_q    <= ACQUIRE;
      good_run_q <= '0;
      bad_run_q  <= '0;
      first_q    <= 1'b1;
      expected_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_run_q <= good_run_d;
      bad_run_q  <= bad_run_d;
      first_q    <= first_d;
      expected_q <= expected_d;
      err_q      <= err_d;
    end
  end

  gbt_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk_ik   (clk_ik),
    .rst_n_ir (rst_n_ir),
    .inc_i    (err_inc),
    .clr_i    (clear_i),
    .cnt_o    (err_cnt_o)
  );

  gbt_sat_counter #(.W(CNT_W)) u_frame_cnt (
    .clk_ik   (clk_ik),
    .rst_n_ir (rst_n_ir),
    .inc_i    (frame_inc),
    .clr_i    (clear_i),
    .cnt_o    (frame_cnt_o)
  );

  assign locked_o   = (state_q == LOCKED);
  assign err_o      = err_q;
  assign expected_o = expected_q;

`ifdef GBT_COUNTER_CHECKER_SNAPSHOT_EN
  logic              snap_done_q;
  logic [DATA_W-1:0] snap_data_q;
  logic [HW-1:0]     snap_exp_q;

  // A clear re-arms the capture; a clear coinciding with a bad frame wins.
  always_ff @(posedge clk_ik) begin
    if (!rst_n_ir || clear_i) begin
      snap_done_q <= 1'b0;
      snap_data_q <= '0;
      snap_exp_q  <= '0;
    end else if (err_inc && !snap_done_q) begin
      snap_done_q <= 1'b1;
      snap_data_q <= data_i;
      snap_exp_q  <= expected_q;
    end
  end

  assign first_err_data_o = snap_data_q;
  assign first_err_exp_o  = snap_exp_q;
`endif

endmodule
